// File: rtl/ahb_bram_ctrl_pkg.sv
// rtl/ahb_bram_ctrl_pkg.sv - shared AHB-Lite encodings for the block-RAM slave
package ahb_bram_ctrl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  localparam logic HRESP_OKAY = 1'b0;

  // Only NONSEQ and SEQ carry a transfer; IDLE and BUSY are ignored.
  function automatic logic trans_starts(logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_bram_ctrl_if.sv
// rtl/ahb_bram_ctrl_if.sv - AHB-Lite slave-side bus bundle
interface ahb_bram_ctrl_if;

  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

endinterface

// File: rtl/ahb_bytemask_dec.sv
// rtl/ahb_bytemask_dec.sv - HSIZE/HADDR[1:0] to 32-bit lane byte mask
module ahb_bytemask_dec
  import ahb_bram_ctrl_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] mask_o
);

  // Sizes above word are clamped to a full-word mask; half ignores addr bit 0.
  always_comb begin
    mask_o = 4'b1111;
    case (hsize_i)
      HSIZE_BYTE: mask_o = 4'b0001 << addr_lo_i;
      HSIZE_HALF: mask_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      default:    mask_o = 4'b1111;
    endcase
  end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// rtl/ahb_bram_ctrl.sv - zero-wait AHB-Lite slave in front of a 1-cycle block RAM
module ahb_bram_ctrl
  import ahb_bram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_bram_ctrl_if.slave        ahb,
  output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
  output logic [31:0]           BRAM_WRDATA,
  output logic [3:0]            BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
  input  logic [31:0]           BRAM_RDATA
);

  logic                  accept;
  logic                  hazard;
  logic [ADDR_WIDTH-1:0] addr_word;
  logic [3:0]            acc_mask;
  logic [31:0]           hrdata;

  logic                  wr_pend_q, wr_pend_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [3:0]            wr_mask_q, wr_mask_d;
  logic [3:0]            fwd_mask_q, fwd_mask_d;
  logic [31:0]           fwd_data_q, fwd_data_d;

  // Upper address bits alias onto the RAM, so they are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^ahb.HADDR[31:ADDR_WIDTH+2];

  assign accept    = ahb.HSEL & ahb.HREADY & trans_starts(ahb.HTRANS);
  assign addr_word = ahb.HADDR[ADDR_WIDTH+1:2];

  ahb_bytemask_dec u_mask (
    .hsize_i   (ahb.HSIZE),
    .addr_lo_i (ahb.HADDR[1:0]),
    .mask_o    (acc_mask)
  );

  // Write port is driven from the registered address phase; data flows straight from HWDATA.
  assign BRAM_WE     = wr_pend_q ? wr_mask_q : 4'b0000;
  assign BRAM_WRADDR = wr_addr_q;
  assign BRAM_WRDATA = ahb.HWDATA;

  // The RAM registers its own read address, so the raw address phase goes out every cycle.
  assign BRAM_RDADDR = addr_word;

  // A read whose word is being written this very cycle would see stale RAM data.
  assign hazard = (BRAM_WE != 4'b0000) && (addr_word == wr_addr_q);

  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = HRESP_OKAY;
  assign ahb.HRDATA    = hrdata;

  // Next-state for address-phase registers; everything holds while another slave stalls the bus.
  always_comb begin
    wr_pend_d  = wr_pend_q;
    rd_pend_d  = rd_pend_q;
    wr_addr_d  = wr_addr_q;
    wr_mask_d  = wr_mask_q;
    fwd_mask_d = fwd_mask_q;
    fwd_data_d = fwd_data_q;
    if (ahb.HREADY) begin
      wr_pend_d = accept & ahb.HWRITE;
      rd_pend_d = accept & ~ahb.HWRITE;
      if (accept && ahb.HWRITE) begin
        wr_addr_d = addr_word;
        wr_mask_d = acc_mask;
      end
      if (accept && !ahb.HWRITE && hazard) begin
        fwd_mask_d = BRAM_WE;
        fwd_data_d = ahb.HWDATA;
      end else begin
        fwd_mask_d = 4'b0000;
      end
    end
  end

  // State registers; reset drops any in-flight write immediately.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_pend_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_mask_q  <= 4'b0000;
      fwd_mask_q <= 4'b0000;
      fwd_data_q <= 32'h0;
    end else begin
      wr_pend_q  <= wr_pend_d;
      rd_pend_q  <= rd_pend_d;
      wr_addr_q  <= wr_addr_d;
      wr_mask_q  <= wr_mask_d;
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  // Read data merge: forwarded bytes override the RAM's pre-write contents lane by lane.
  always_comb begin
    hrdata = BRAM_RDATA;
    for (int i = 0; i < 4; i++) begin
      if (rd_pend_q && fwd_mask_q[i]) begin
        hrdata[8*i +: 8] = fwd_data_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// tb/tb_ahb_bram_ctrl.sv - self-checking bench for ahb_bram_ctrl
module tb_ahb_bram_ctrl;
  import ahb_bram_ctrl_pkg::*;

  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } op_t;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [AW-1:0] BRAM_WRADDR, BRAM_RDADDR;
  logic [31:0]   BRAM_WRDATA, BRAM_RDATA;
  logic [3:0]    BRAM_WE;

  int vectors = 0;
  int miscompares = 0;

  ahb_bram_ctrl_if bus ();

  ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .ahb         (bus.slave),
    .BRAM_WRADDR (BRAM_WRADDR),
    .BRAM_WRDATA (BRAM_WRDATA),
    .BRAM_WE     (BRAM_WE),
    .BRAM_RDADDR (BRAM_RDADDR),
    .BRAM_RDATA  (BRAM_RDATA)
  );

  always #5 HCLK = ~HCLK;

  // Block RAM: byte-enabled write, registered read returning pre-write contents.
  logic [31:0] bram [0:DEPTH-1];
  bit          bram_cleared;
  always @(posedge HCLK) begin
    if (!bram_cleared) begin
      for (int i = 0; i < DEPTH; i++) bram[i] <= 32'h0;
      bram_cleared <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (BRAM_WE[b]) bram[BRAM_WRADDR][8*b +: 8] <= BRAM_WRDATA[8*b +: 8];
    end
    BRAM_RDATA <= bram[BRAM_RDADDR];
  end

  // Reference model: memory as seen in program order of accepted transfers.
  logic [31:0] ref_mem [int];

  function automatic logic [3:0] ref_mask(logic [31:0] a, logic [2:0] s);
    if (s == 3'd0) return 4'b0001 << a[1:0];
    if (s == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    int w = int'(a[AW+1:2]);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  task automatic ref_wr(logic [31:0] a, logic [2:0] s, logic [31:0] d);
    logic [31:0] v = ref_rd(a);
    logic [3:0]  m = ref_mask(a, s);
    for (int b = 0; b < 4; b++) if (m[b]) v[8*b +: 8] = d[8*b +: 8];
    ref_mem[int'(a[AW+1:2])] = v;
  endtask

  function automatic op_t mk(logic wr, logic [31:0] a, logic [2:0] s, logic [31:0] d);
    op_t o;
    o.sel = 1'b1; o.trans = HTRANS_NONSEQ; o.wr = wr; o.addr = a; o.size = s; o.data = d;
    return o;
  endfunction

  function automatic op_t mk_idle();
    op_t o;
    o.sel = 1'b0; o.trans = HTRANS_IDLE; o.wr = 1'b0; o.addr = 32'h0; o.size = 3'd0; o.data = 32'h0;
    return o;
  endfunction

  op_t           ops[$];
  logic [3:0]    obs_we[$], exp_we[$];
  logic [AW-1:0] obs_wa[$], exp_wa[$];
  logic [31:0]   obs_rd[$], exp_rd[$];
  logic          obs_hro[$], obs_hresp[$];
  int            exp_kind[$];   // 0 none, 1 write, 2 read

  task automatic drive_idle();
    bus.HSEL = 1'b0; bus.HTRANS = HTRANS_IDLE; bus.HWRITE = 1'b0;
    bus.HADDR = 32'h0; bus.HSIZE = 3'd0; bus.HREADY = 1'b1;
  endtask

  // Pipelined driver: op i's address phase overlaps op i-1's data phase.
  task automatic run_ops();
    int n = ops.size();
    obs_we.delete(); obs_wa.delete(); obs_rd.delete(); obs_hro.delete(); obs_hresp.delete();
    exp_we.delete(); exp_wa.delete(); exp_rd.delete(); exp_kind.delete();
    for (int i = 0; i <= n; i++) begin
      @(negedge HCLK);
      if (i > 0 && ops[i-1].sel && ops[i-1].trans[1] && ops[i-1].wr) bus.HWDATA = ops[i-1].data;
      else bus.HWDATA = $urandom;
      if (i < n) begin
        bus.HSEL = ops[i].sel; bus.HTRANS = ops[i].trans; bus.HWRITE = ops[i].wr;
        bus.HADDR = ops[i].addr; bus.HSIZE = ops[i].size; bus.HREADY = 1'b1;
        if (ops[i].sel && ops[i].trans[1] && ops[i].wr) begin
          exp_kind.push_back(1); exp_we.push_back(ref_mask(ops[i].addr, ops[i].size));
          exp_wa.push_back(ops[i].addr[AW+1:2]); exp_rd.push_back(32'h0);
          ref_wr(ops[i].addr, ops[i].size, ops[i].data);
        end else if (ops[i].sel && ops[i].trans[1]) begin
          exp_kind.push_back(2); exp_we.push_back(4'h0); exp_wa.push_back('0);
          exp_rd.push_back(ref_rd(ops[i].addr));
        end else begin
          exp_kind.push_back(0); exp_we.push_back(4'h0); exp_wa.push_back('0); exp_rd.push_back(32'h0);
        end
      end else begin
        drive_idle();
      end
      #1;
      if (i > 0) begin
        obs_we.push_back(BRAM_WE); obs_wa.push_back(BRAM_WRADDR); obs_rd.push_back(bus.HRDATA);
        obs_hro.push_back(bus.HREADYOUT); obs_hresp.push_back(bus.HRESP);
      end
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    bus.HSEL = 1'b1; bus.HTRANS = HTRANS_NONSEQ; bus.HWRITE = 1'b1; bus.HADDR = 32'h10;
    bus.HSIZE = 3'd2; bus.HREADY = 1'b1; bus.HWDATA = 32'hFFFF_FFFF;
    repeat (3) @(negedge HCLK);
    #1;
    vectors++; if (BRAM_WE !== 4'h0) begin miscompares++; $display("FAIL reset_we: got %h expected 0", BRAM_WE); end
    vectors++; if (bus.HREADYOUT !== 1'b1) begin miscompares++; $display("FAIL reset_hreadyout: got %b expected 1", bus.HREADYOUT); end
    vectors++; if (bus.HRESP !== 1'b0) begin miscompares++; $display("FAIL reset_hresp: got %b expected 0", bus.HRESP); end
    @(negedge HCLK);
    drive_idle();
    HRESETn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK); #1;
      vectors++; if (BRAM_WE !== 4'h0) begin miscompares++; $display("FAIL idle_we[%0d]: got %h expected 0", i, BRAM_WE); end
    end
  endtask

  task automatic test_word_rw();
    ops.delete();
    ops.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEADBEEF));
    ops.push_back(mk_idle());
    ops.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0));
    run_ops();
    vectors++; if (obs_we[0] !== 4'hF) begin miscompares++; $display("FAIL word_we: got %h expected f", obs_we[0]); end
    vectors++; if (obs_wa[0] !== 14'd4) begin miscompares++; $display("FAIL word_wraddr: got %0d expected 4", obs_wa[0]); end
    vectors++; if (obs_we[1] !== 4'h0) begin miscompares++; $display("FAIL idle_after_write_we: got %h expected 0", obs_we[1]); end
    vectors++; if (obs_rd[2] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL word_rdata: got %h expected deadbeef", obs_rd[2]); end
  endtask

  task automatic test_subword();
    ops.delete();
    ops.push_back(mk(1'b1, 32'h13, 3'd0, {8'hAA, 24'($urandom)}));
    ops.push_back(mk(1'b1, 32'h12, 3'd1, {16'h1234, 16'($urandom)}));
    ops.push_back(mk_idle());
    ops.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0));
    run_ops();
    vectors++; if (obs_we[0] !== 4'b1000) begin miscompares++; $display("FAIL byte_we: got %b expected 1000", obs_we[0]); end
    vectors++; if (obs_we[1] !== 4'b1100) begin miscompares++; $display("FAIL half_we: got %b expected 1100", obs_we[1]); end
    vectors++; if (obs_rd[3] !== 32'h1234BEEF) begin miscompares++; $display("FAIL subword_rdata: got %h expected 1234beef", obs_rd[3]); end
  endtask

  task automatic test_hazard();
    ops.delete();
    ops.push_back(mk(1'b1, 32'h10, 3'd2, 32'h11223344));
    ops.push_back(mk_idle());
    ops.push_back(mk(1'b1, 32'h11, 3'd0, {16'($urandom), 8'h55, 8'($urandom)}));
    ops.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0));
    ops.push_back(mk_idle());
    ops.push_back(mk(1'b1, 32'h14, 3'd2, 32'hC0FFEE01));
    ops.push_back(mk_idle());
    ops.push_back(mk(1'b1, 32'h11, 3'd0, {16'($urandom), 8'h77, 8'($urandom)}));
    ops.push_back(mk(1'b0, 32'h14, 3'd2, 32'h0));
    ops.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0));
    run_ops();
    vectors++; if (obs_rd[3] !== 32'h11225544) begin miscompares++; $display("FAIL raw_forward: got %h expected 11225544", obs_rd[3]); end
    vectors++; if (obs_rd[8] !== 32'hC0FFEE01) begin miscompares++; $display("FAIL raw_other_word: got %h expected c0ffee01", obs_rd[8]); end
    vectors++; if (obs_rd[9] !== 32'h11227744) begin miscompares++; $display("FAIL raw_two_later: got %h expected 11227744", obs_rd[9]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] wdat [8];
    ops.delete();
    for (int i = 0; i < 8; i++) begin
      wdat[i] = $urandom;
      ops.push_back(mk(1'b1, 32'(i * 4), 3'd2, wdat[i]));
      if (i > 0) ops[i].trans = HTRANS_SEQ;
    end
    for (int i = 0; i < 8; i++) begin
      ops.push_back(mk(1'b0, 32'(i * 4), 3'd2, 32'h0));
      if (i > 0) ops[8+i].trans = HTRANS_SEQ;
    end
    run_ops();
    for (int i = 0; i < 16; i++) begin
      vectors++; if (obs_hro[i] !== 1'b1) begin miscompares++; $display("FAIL b2b_hreadyout[%0d]: got %b expected 1", i, obs_hro[i]); end
    end
    for (int i = 0; i < 8; i++) begin
      vectors++; if (obs_we[i] !== 4'hF || obs_wa[i] !== AW'(i)) begin
        miscompares++; $display("FAIL b2b_write[%0d]: got we=%h addr=%0d expected we=f addr=%0d", i, obs_we[i], obs_wa[i], i);
      end
      vectors++; if (obs_rd[8+i] !== wdat[i]) begin
        miscompares++; $display("FAIL b2b_read[%0d]: got %h expected %h", i, obs_rd[8+i], wdat[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] d = $urandom;
    @(negedge HCLK);
    bus.HSEL = 1'b1; bus.HTRANS = HTRANS_NONSEQ; bus.HWRITE = 1'b1;
    bus.HADDR = 32'h20; bus.HSIZE = 3'd2; bus.HREADY = 1'b1;
    ref_wr(32'h20, 3'd2, d);
    @(negedge HCLK);
    drive_idle(); bus.HREADY = 1'b0; bus.HWDATA = d;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge HCLK);
      #1;
      vectors++; if (BRAM_WE !== 4'hF || BRAM_WRADDR !== 14'd8 || BRAM_WRDATA !== d) begin
        miscompares++; $display("FAIL stall_hold[%0d]: got we=%h addr=%0d data=%h expected we=f addr=8 data=%h", i, BRAM_WE, BRAM_WRADDR, BRAM_WRDATA, d);
      end
    end
    @(negedge HCLK);
    bus.HREADY = 1'b1; #1;
    vectors++; if (BRAM_WE !== 4'hF) begin miscompares++; $display("FAIL stall_release_we: got %h expected f", BRAM_WE); end
    @(negedge HCLK); #1;
    vectors++; if (BRAM_WE !== 4'h0) begin miscompares++; $display("FAIL stall_after_we: got %h expected 0", BRAM_WE); end
    ops.delete();
    ops.push_back(mk(1'b0, 32'h20, 3'd2, 32'h0));
    run_ops();
    vectors++; if (obs_rd[0] !== d) begin miscompares++; $display("FAIL stall_rdata: got %h expected %h", obs_rd[0], d); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] old_v = $urandom;
    logic [31:0] new_v = ~old_v;
    ops.delete();
    ops.push_back(mk(1'b1, 32'h24, 3'd2, old_v));
    run_ops();
    @(negedge HCLK);
    bus.HSEL = 1'b1; bus.HTRANS = HTRANS_NONSEQ; bus.HWRITE = 1'b1;
    bus.HADDR = 32'h24; bus.HSIZE = 3'd2; bus.HREADY = 1'b1;
    @(negedge HCLK);
    drive_idle(); bus.HWDATA = new_v; #1;
    vectors++; if (BRAM_WE !== 4'hF) begin miscompares++; $display("FAIL abort_pre_we: got %h expected f", BRAM_WE); end
    #1 HRESETn = 1'b0;
    #1;
    vectors++; if (BRAM_WE !== 4'h0) begin miscompares++; $display("FAIL abort_we: got %h expected 0", BRAM_WE); end
    vectors++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin
      miscompares++; $display("FAIL abort_resp: got hreadyout=%b hresp=%b expected 1 0", bus.HREADYOUT, bus.HRESP);
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    ops.delete();
    ops.push_back(mk(1'b0, 32'h24, 3'd2, 32'h0));
    run_ops();
    vectors++; if (obs_rd[0] !== old_v) begin miscompares++; $display("FAIL abort_rdata: got %h expected %h", obs_rd[0], old_v); end
  endtask

  task automatic test_random();
    op_t o;
    int  r;
    ops.delete();
    for (int i = 0; i < 300; i++) begin
      o.sel  = ($urandom_range(0, 7) != 0);
      r      = $urandom_range(0, 5);
      o.trans = (r == 0) ? HTRANS_IDLE : (r == 1) ? HTRANS_BUSY : (r[0] ? HTRANS_SEQ : HTRANS_NONSEQ);
      o.wr   = $urandom_range(0, 1);
      o.addr = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 63));
      o.size = 3'($urandom_range(0, 7));
      o.data = $urandom;
      ops.push_back(o);
    end
    run_ops();
    for (int i = 0; i < 300; i++) begin
      vectors++; if (obs_hro[i] !== 1'b1 || obs_hresp[i] !== 1'b0) begin
        miscompares++; $display("FAIL rand_resp[%0d]: got hreadyout=%b hresp=%b expected 1 0", i, obs_hro[i], obs_hresp[i]);
      end
      if (exp_kind[i] == 1) begin
        vectors++; if (obs_we[i] !== exp_we[i] || obs_wa[i] !== exp_wa[i]) begin
          miscompares++; $display("FAIL rand_write[%0d]: got we=%h addr=%0d expected we=%h addr=%0d", i, obs_we[i], obs_wa[i], exp_we[i], exp_wa[i]);
        end
      end else if (exp_kind[i] == 2) begin
        vectors++; if (obs_rd[i] !== exp_rd[i]) begin
          miscompares++; $display("FAIL rand_read[%0d]: got %h expected %h", i, obs_rd[i], exp_rd[i]);
        end
      end else begin
        vectors++; if (obs_we[i] !== 4'h0) begin
          miscompares++; $display("FAIL rand_idle_we[%0d]: got %h expected 0", i, obs_we[i]);
        end
      end
    end
  endtask

  initial begin
    drive_idle();
    bus.HWDATA = 32'h0;
    HRESETn = 1'b0;
    test_reset();
    test_word_rw();
    test_subword();
    test_hazard();
    test_back_to_back();
    test_stall();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
